csp2_1: RTL and testbench
=========================

# csp2_1

Fixed-geometry YOLOv5 CSP2_1 bottleneck for the FPGA inference path: five CBS (convolution, batch-norm, activation) stages in FP16 on a 3×4×4 feature map, producing a 2×2×2 output.
- Branch A: cbs11 (3×3 valid) → cbs12 (1×1) → cbs13 (3×3, pad 1).
- Branch B: cbs2 (3×3 valid).
- Concat, then the cbso 1×1 fusion layer.
- Fully parallel datapath with four registered pipeline stages; sits between backbone CBS layers.

## Interface
- DATA_WIDTH, 16: element width, IEEE binary16.
- D, 3: input depth.
- H, 4 / W, 4: input height / width.
- F, 3: kernel size of cbs11, cbs2, cbs13 (cbs12 and cbso are 1×1).
- cbs11_K / cbs2_K / cbs12_K / cbs13_K / cbso_K, 2/2/2/3/2: filter counts.
- <s>_beta, <s>_gama, <s>_quarter for s ∈ {cbs11, cbs2, cbs12, cbs13, cbso}:
  - defaults 16'h0000 (0), 16'h3C00 (1.0), 16'h3400 (0.25 = 1/spatial size);
  - these are the BN shift, scale and mean divisor.
- clk  input  1: single clock, rising edge.
- reset  input  1: asynchronous, active-low.
- x  input  D·H·W·16: input map.
- cbs11_filters  input  2·3·9·16.
- cbs12_filters  input  2·2·1·16.
- cbs13_filters  input  3·2·9·16.
- cbs2_filters  input  2·3·9·16.
- cbso_filters  input  2·5·1·16.
- out  output  8·16: result map, 2 channels × 2×2.
- Port order is exactly as listed above.

## Operation
- Packing:
  - Map element (d,r,c) is at bits [((d·Hm+r)·Wm+c)·16 +:16].
  - Filter k, tap (d,r,c) is at block offset k·Dk·Fk·Fk + (d·Fk+r)·Fk + c.
  - Output channel k is at index (k·2+r)·2+c.
- Stage shapes:
  - cbs11 and cbs2: 3×4×4 → 2×2×2, valid.
  - cbs12: 2×2×2 → 2×2×2.
  - cbs13: 2×2×2 zero-padded to 2×4×4 → 3×2×2.
  - Concat: 5 channels; cbs13 channels at indices 0–2, cbs2 channels at indices 3–4.
  - cbso: 5×2×2 → 2×2×2.
- Convolution: accumulator starts at +0; MACs run in ascending d, then r, then c order: acc = add(acc, mul(x, w)).
- FP16 rules, applied to every mul and add:
  - subnormal inputs and results flush to signed zero;
  - results truncate (round toward zero);
  - exponent overflow saturates to ±0x7BFF;
  - NaN/Inf are not supported.
- BN, per channel, spatial positions summed in ascending order:
  - mean = mul(quarter, sum);
  - y = add(mul(gama, add(v, −mean)), beta).
- Activation (hard-SiLU):
  - h = add(mul(0x3400, y), 0x3800);
  - clamp h to [+0, 0x3C00];
  - a = mul(y, h); the sign of a is sign(y) XOR sign(h).

## Timing
- Pipeline registers capture on each rising clk:
  - R1 holds cbs11/cbs2;
  - R2 holds cbs12;
  - R3 holds cbs13 plus the delayed cbs2;
  - R4 drives out.
- Latency: 4 cycles. A stable input change before edge n appears on out after edge n+3.
- Throughput: one new input set per cycle.
- reset low:
  - all registers clear to 16'h0000 immediately, without waiting for clk;
  - out = 0 for as long as reset is low.
- After reset deasserts, out stays 0 until the first edge that captures valid R3 data.
- Reset asserted mid-stream discards all in-flight data.

## Configuration
- CSP2_1_BN_EN defined: the BN step runs in all five CBS stages as specified above.
- CSP2_1_BN_EN undefined: BN is bypassed (y = v) and the beta/gama/quarter parameters are unused.

## Test plan
- Reset: hold reset=0 with random inputs → out = 0 at all times; release reset, inputs all zero → out stays 0.
- No BN; x and all filters = 0x3C00, reset released:
  - cbs11 = cbs2 = 0x4EC0 (27);
  - cbs12 = 0x52C0 (54);
  - cbs13 = 0x5EC0 (432);
  - all 8 out = 0x6546 (1350) after 4 edges.
- Same stimulus, but cbso_filters all = 0xBC00 → cbso = −1350, h clamps to +0, all out = 0x8000.
- With CSP2_1_BN_EN, defaults, stimulus as in the second scenario → each channel's mean equals its values → all out = 0x0000.
- Latency: switch x from all-zero to all-ones between edges 10 and 11, filters fixed as in the second scenario → out is 0 through edge 13 and 0x6546 after edge 14.
- Mid-stream reset: pulse reset low for half a cycle during streaming → out = 0 immediately; resume data → valid out 4 edges after release.

Source files
------------

// File: rtl/csp2_1.sv
// csp2_1: fixed-geometry YOLOv5 CSP2_1 bottleneck in FP16.
// Branch A: cbs11 (3x3 valid) -> cbs12 (1x1) -> cbs13 (3x3 pad 1); branch B: cbs2.
// The concat of both branches feeds the cbso 1x1 fusion layer. Four registered stages.
// Optional feature macro: CSP2_1_BN_EN (defined: batch-norm active in every CBS stage;
// undefined: BN bypassed and the beta/gama/quarter parameters are ignored).

package csp2_1_fp_pkg;

  // FP16 multiply: subnormals flush to signed zero, truncation, saturation to +-0x7BFF.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] p;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'h0000};
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) e = e + 1;
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return {s, 15'h7BFF};
    return {s, 5'(e), 10'(p >> (p[21] ? 11 : 10))};
  endfunction

  // FP16 add: operands aligned exactly on a wide integer so truncation sees every bit.
  // A smaller operand more than 20 binades down only matters through its sign, so the
  // alignment shift is capped there to bound the adder width.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [33:0] ma;
    logic [33:0] mb;
    logic [33:0] sum;
    logic [9:0]  m;
    int          ea;
    int          eb;
    int          sh;
    int          eu;
    int          p;
    int          e;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 && eb == 0) return {a[15] & b[15], 15'h0000};
    if (ea == 0) return b;
    if (eb == 0) return a;
    ma = {23'd0, 1'b1, a[9:0]};
    mb = {23'd0, 1'b1, b[9:0]};
    if (ea >= eb) begin
      sh = (ea - eb > 20) ? 20 : ea - eb;
      ma = ma << sh;
      eu = ea - sh;
    end else begin
      sh = (eb - ea > 20) ? 20 : eb - ea;
      mb = mb << sh;
      eu = eb - sh;
    end
    if (a[15] == b[15]) begin
      sum = ma + mb;
      s   = a[15];
    end else if (ma > mb) begin
      sum = ma - mb;
      s   = a[15];
    end else if (mb > ma) begin
      sum = mb - ma;
      s   = b[15];
    end else begin
      return 16'h0000;
    end
    p = 0;
    for (int i = 0; i < 34; i++) if (sum[i]) p = i;
    e = eu + p - 10;
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return {s, 15'h7BFF};
    m = (p >= 10) ? 10'(sum >> (p - 10)) : 10'(sum << (10 - p));
    return {s, 5'(e), m};
  endfunction

  // Hard-SiLU: a = y * clamp(y/4 + 1/2, +0, 1).
  function automatic logic [15:0] fp_hsilu(input logic [15:0] y);
    logic [15:0] h;
    h = fp_add(fp_mul(16'h3400, y), 16'h3800);
    if (h[15]) h = 16'h0000;
    else if (h[14:0] > 15'h3C00) h = 16'h3C00;
    return fp_mul(y, h);
  endfunction

endpackage

module csp2_1_cbs
  import csp2_1_fp_pkg::*;
#(
  parameter int          DIN     = 3,
  parameter int          HIN     = 4,
  parameter int          WIN     = 4,
  parameter int          PAD     = 0,
  parameter int          FK      = 3,
  parameter int          NK      = 2,
  parameter logic [15:0] BETA    = 16'h0000,
  parameter logic [15:0] GAMA    = 16'h3C00,
  parameter logic [15:0] QUARTER = 16'h3400,
  localparam int         HO      = HIN + 2 * PAD - FK + 1,
  localparam int         WO      = WIN + 2 * PAD - FK + 1,
  localparam int         NPIX    = HO * WO
) (
  input  logic [DIN*HIN*WIN*16-1:0]  in_map,
  input  logic [NK*DIN*FK*FK*16-1:0] filters,
  output logic [NK*NPIX*16-1:0]      out_map
);

  logic [15:0] conv_val [NK*NPIX];
  logic [15:0] bn_val   [NK*NPIX];

  // One output point; taps falling in the zero padding still go through the MAC chain.
  function automatic logic [15:0] conv_point(input int k, input int r, input int c);
    logic [15:0] acc;
    logic [15:0] v;
    int          rr;
    int          cc;
    acc = 16'h0000;
    for (int d = 0; d < DIN; d++)
      for (int i = 0; i < FK; i++)
        for (int j = 0; j < FK; j++) begin
          rr = r + i - PAD;
          cc = c + j - PAD;
          if (rr >= 0 && rr < HIN && cc >= 0 && cc < WIN)
            v = in_map[((d * HIN + rr) * WIN + cc) * 16 +: 16];
          else
            v = 16'h0000;
          acc = fp_add(acc, fp_mul(v, filters[(k * DIN * FK * FK + (d * FK + i) * FK + j) * 16 +: 16]));
        end
    return acc;
  endfunction

  // Convolution of every output point in parallel.
  always_comb begin
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < HO; r++)
        for (int c = 0; c < WO; c++)
          conv_val[(k * HO + r) * WO + c] = conv_point(k, r, c);
  end

`ifdef CSP2_1_BN_EN
  logic [15:0] ch_sum  [NK];
  logic [15:0] ch_mean [NK];

  // Per-channel batch-norm: subtract the channel mean, then scale and shift.
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      ch_sum[k] = 16'h0000;
      for (int p = 0; p < NPIX; p++) ch_sum[k] = fp_add(ch_sum[k], conv_val[k * NPIX + p]);
      ch_mean[k] = fp_mul(QUARTER, ch_sum[k]);
      for (int p = 0; p < NPIX; p++)
        bn_val[k * NPIX + p] = fp_add(fp_mul(GAMA, fp_add(conv_val[k * NPIX + p],
                                                          {~ch_mean[k][15], ch_mean[k][14:0]})), BETA);
    end
  end
`else
  logic unused_bn_params;
  assign unused_bn_params = ^{BETA, GAMA, QUARTER};

  // Batch-norm bypassed: activation sees the raw convolution.
  always_comb begin
    for (int i = 0; i < NK * NPIX; i++) bn_val[i] = conv_val[i];
  end
`endif

  // Hard-SiLU activation on every element.
  always_comb begin
    out_map = '0;
    for (int i = 0; i < NK * NPIX; i++) out_map[i*16 +: 16] = fp_hsilu(bn_val[i]);
  end

endmodule

module csp2_1 #(
  parameter int          DATA_WIDTH    = 16,
  parameter int          D             = 3,
  parameter int          H             = 4,
  parameter int          W             = 4,
  parameter int          F             = 3,
  parameter int          cbs11_K       = 2,
  parameter int          cbs2_K        = 2,
  parameter int          cbs12_K       = 2,
  parameter int          cbs13_K       = 3,
  parameter int          cbso_K        = 2,
  parameter logic [15:0] cbs11_beta    = 16'h0000,
  parameter logic [15:0] cbs11_gama    = 16'h3C00,
  parameter logic [15:0] cbs11_quarter = 16'h3400,
  parameter logic [15:0] cbs2_beta     = 16'h0000,
  parameter logic [15:0] cbs2_gama     = 16'h3C00,
  parameter logic [15:0] cbs2_quarter  = 16'h3400,
  parameter logic [15:0] cbs12_beta    = 16'h0000,
  parameter logic [15:0] cbs12_gama    = 16'h3C00,
  parameter logic [15:0] cbs12_quarter = 16'h3400,
  parameter logic [15:0] cbs13_beta    = 16'h0000,
  parameter logic [15:0] cbs13_gama    = 16'h3C00,
  parameter logic [15:0] cbs13_quarter = 16'h3400,
  parameter logic [15:0] cbso_beta     = 16'h0000,
  parameter logic [15:0] cbso_gama     = 16'h3C00,
  parameter logic [15:0] cbso_quarter  = 16'h3400,
  localparam int         HO            = H - F + 1,
  localparam int         WO            = W - F + 1,
  localparam int         PIX           = HO * WO
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [D*H*W*DATA_WIDTH-1:0]                   x,
  input  logic [cbs11_K*D*F*F*DATA_WIDTH-1:0]           cbs11_filters,
  input  logic [cbs12_K*cbs11_K*DATA_WIDTH-1:0]         cbs12_filters,
  input  logic [cbs13_K*cbs12_K*F*F*DATA_WIDTH-1:0]     cbs13_filters,
  input  logic [cbs2_K*D*F*F*DATA_WIDTH-1:0]            cbs2_filters,
  input  logic [cbso_K*(cbs13_K+cbs2_K)*DATA_WIDTH-1:0] cbso_filters,
  output logic [cbso_K*PIX*DATA_WIDTH-1:0]              out
);

  logic [cbs11_K*PIX*DATA_WIDTH-1:0] cbs11_v, r1_cbs11;
  logic [cbs2_K*PIX*DATA_WIDTH-1:0]  cbs2_v, r1_cbs2, r2_cbs2, r3_cbs2;
  logic [cbs12_K*PIX*DATA_WIDTH-1:0] cbs12_v, r2_cbs12;
  logic [cbs13_K*PIX*DATA_WIDTH-1:0] cbs13_v, r3_cbs13;
  logic [cbso_K*PIX*DATA_WIDTH-1:0]  cbso_v, r4_out;

  csp2_1_cbs #(.DIN(D), .HIN(H), .WIN(W), .PAD(0), .FK(F), .NK(cbs11_K),
               .BETA(cbs11_beta), .GAMA(cbs11_gama), .QUARTER(cbs11_quarter))
    u_cbs11 (.in_map(x), .filters(cbs11_filters), .out_map(cbs11_v));

  csp2_1_cbs #(.DIN(D), .HIN(H), .WIN(W), .PAD(0), .FK(F), .NK(cbs2_K),
               .BETA(cbs2_beta), .GAMA(cbs2_gama), .QUARTER(cbs2_quarter))
    u_cbs2 (.in_map(x), .filters(cbs2_filters), .out_map(cbs2_v));

  csp2_1_cbs #(.DIN(cbs11_K), .HIN(HO), .WIN(WO), .PAD(0), .FK(1), .NK(cbs12_K),
               .BETA(cbs12_beta), .GAMA(cbs12_gama), .QUARTER(cbs12_quarter))
    u_cbs12 (.in_map(r1_cbs11), .filters(cbs12_filters), .out_map(cbs12_v));

  csp2_1_cbs #(.DIN(cbs12_K), .HIN(HO), .WIN(WO), .PAD((F - 1) / 2), .FK(F), .NK(cbs13_K),
               .BETA(cbs13_beta), .GAMA(cbs13_gama), .QUARTER(cbs13_quarter))
    u_cbs13 (.in_map(r2_cbs12), .filters(cbs13_filters), .out_map(cbs13_v));

  csp2_1_cbs #(.DIN(cbs13_K + cbs2_K), .HIN(HO), .WIN(WO), .PAD(0), .FK(1), .NK(cbso_K),
               .BETA(cbso_beta), .GAMA(cbso_gama), .QUARTER(cbso_quarter))
    u_cbso (.in_map({r3_cbs2, r3_cbs13}), .filters(cbso_filters), .out_map(cbso_v));

  // Pipeline registers; cbs2 rides alongside branch A until the concat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_cbs11 <= '0;
      r1_cbs2  <= '0;
      r2_cbs12 <= '0;
      r2_cbs2  <= '0;
      r3_cbs13 <= '0;
      r3_cbs2  <= '0;
      r4_out   <= '0;
    end else begin
      r1_cbs11 <= cbs11_v;
      r1_cbs2  <= cbs2_v;
      r2_cbs12 <= cbs12_v;
      r2_cbs2  <= r1_cbs2;
      r3_cbs13 <= cbs13_v;
      r3_cbs2  <= r2_cbs2;
      r4_out   <= cbso_v;
    end
  end

  assign out = r4_out;

endmodule

// File: tb/tb_csp2_1.sv
// tb_csp2_1: directed and randomized checks of csp2_1 against a real-arithmetic FP16 model.
// Build with CSP2_1_BN_EN defined to check the batch-norm variant.

module tb_csp2_1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [767:0] x;
  logic [863:0] f11;
  logic [63:0]  f12;
  logic [863:0] f13;
  logic [863:0] f2;
  logic [159:0] fo;
  logic [127:0] out;

  int checks = 0;
  int errors = 0;

  csp2_1 dut (
    .clk(clk), .reset(reset), .x(x),
    .cbs11_filters(f11), .cbs12_filters(f12), .cbs13_filters(f13),
    .cbs2_filters(f2), .cbso_filters(fo), .out(out)
  );

  always #5 clk = ~clk;

  // Real value of an FP16 pattern; exponent-zero patterns count as zero.
  function automatic real m_val(input logic [15:0] a);
    real r;
    int  e;
    if (a[14:10] == 5'd0) return 0.0;
    r = real'(1024 + int'(a[9:0])) / 1024.0;
    e = int'(a[14:10]) - 15;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i < -e; i++) r = r / 2.0;
    return a[15] ? -r : r;
  endfunction

  // Nonzero real to FP16 with truncation, flush-to-zero and saturation.
  function automatic logic [15:0] m_pack(input real r);
    logic s;
    real  m;
    int   e;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    if (e + 15 >= 31) return {s, 15'h7BFF};
    if (e + 15 <= 0) return {s, 15'h0000};
    return {s, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {a[15] ^ b[15], 15'h0000};
    return m_pack(m_val(a) * m_val(b));
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'h0000};
    return m_pack(m_val(a) + m_val(b));
  endfunction

  function automatic logic [15:0] m_act(input logic [15:0] y);
    logic [15:0] h;
    h = m_add(m_mul(16'h3400, y), 16'h3800);
    if (m_val(h) <= 0.0) h = 16'h0000;
    else if (m_val(h) > 1.0) h = 16'h3C00;
    return m_mul(y, h);
  endfunction

  // One CBS stage on a map of din x hin x win with nk filters of fk x fk.
  function automatic logic [767:0] m_cbs(input logic [767:0] in_map, input int din, input int hin,
                                          input int win, input int pad, input logic [863:0] flt,
                                          input int nk, input int fk);
    logic [767:0] res;
    logic [15:0]  vals [16];
    logic [15:0]  acc;
    logic [15:0]  v;
    logic [15:0]  sum;
    logic [15:0]  mean;
    int ho, wo, rr, cc;
    ho = hin + 2 * pad - fk + 1;
    wo = win + 2 * pad - fk + 1;
    for (int k = 0; k < nk; k++)
      for (int r = 0; r < ho; r++)
        for (int c = 0; c < wo; c++) begin
          acc = 16'h0000;
          for (int d = 0; d < din; d++)
            for (int i = 0; i < fk; i++)
              for (int j = 0; j < fk; j++) begin
                rr = r + i - pad;
                cc = c + j - pad;
                v = (rr >= 0 && rr < hin && cc >= 0 && cc < win) ?
                    in_map[((d * hin + rr) * win + cc) * 16 +: 16] : 16'h0000;
                acc = m_add(acc, m_mul(v, flt[(k * din * fk * fk + (d * fk + i) * fk + j) * 16 +: 16]));
              end
          vals[(k * ho + r) * wo + c] = acc;
        end
`ifdef CSP2_1_BN_EN
    for (int k = 0; k < nk; k++) begin
      sum = 16'h0000;
      for (int p = 0; p < ho * wo; p++) sum = m_add(sum, vals[k * ho * wo + p]);
      mean = m_mul(16'h3400, sum);
      for (int p = 0; p < ho * wo; p++)
        vals[k * ho * wo + p] = m_add(m_mul(16'h3C00, m_add(vals[k * ho * wo + p], mean ^ 16'h8000)), 16'h0000);
    end
`endif
    res = '0;
    for (int i = 0; i < nk * ho * wo; i++) res[i*16 +: 16] = m_act(vals[i]);
    return res;
  endfunction

  function automatic logic [127:0] model_csp();
    logic [767:0] a1, b1, a2, a3, o;
    a1 = m_cbs(x, 3, 4, 4, 0, f11, 2, 3);
    b1 = m_cbs(x, 3, 4, 4, 0, f2, 2, 3);
    a2 = m_cbs(a1, 2, 2, 2, 0, {800'd0, f12}, 2, 1);
    a3 = m_cbs(a2, 2, 2, 2, 1, f13, 3, 3);
    o  = m_cbs({448'd0, b1[127:0], a3[191:0]}, 5, 2, 2, 0, {704'd0, fo}, 2, 1);
    return o[127:0];
  endfunction

  // Moderate-magnitude FP16 with an occasional subnormal to exercise flushing.
  function automatic logic [15:0] rnd_fp();
    logic [15:0] r;
    r = 16'($urandom);
    if ($urandom_range(0, 15) == 0) r[14:10] = 5'd0;
    else r[14:10] = 5'($urandom_range(12, 16));
    return r;
  endfunction

  task automatic set_all(input logic [15:0] xv, input logic [15:0] fv, input logic [15:0] fov);
    x   = {48{xv}};
    f11 = {54{fv}};
    f12 = {4{fv}};
    f13 = {54{fv}};
    f2  = {54{fv}};
    fo  = {10{fov}};
  endtask

  task automatic randomize_x();
    for (int i = 0; i < 48; i++) x[i*16 +: 16] = rnd_fp();
  endtask

  task automatic randomize_filters();
    for (int i = 0; i < 54; i++) begin
      f11[i*16 +: 16] = rnd_fp();
      f13[i*16 +: 16] = rnd_fp();
      f2[i*16 +: 16]  = rnd_fp();
    end
    for (int i = 0; i < 4; i++) f12[i*16 +: 16] = rnd_fp();
    for (int i = 0; i < 10; i++) fo[i*16 +: 16] = rnd_fp();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] expected);
    checks++;
    assert (out === expected) else begin
      errors++;
      $error("[TB] FAIL %s: out=%h expected=%h", tag, out, expected);
    end
  endtask

  logic [127:0] exp_ones;
  logic [127:0] exp_neg;
  logic [127:0] exp_q [8];

  initial begin
`ifdef CSP2_1_BN_EN
    exp_ones = '0;
    exp_neg  = '0;
`else
    exp_ones = {8{16'h6546}};
    exp_neg  = {8{16'h8000}};
`endif
    set_all(16'h0000, 16'h0000, 16'h0000);
    #1 reset = 1'b0;
    $display("[TB] reset held low with random inputs");
    for (int i = 0; i < 4; i++) begin
      randomize_x();
      randomize_filters();
      step();
      check_output("reset_hold", '0);
    end
    #3 check_output("reset_hold_midcycle", '0);

    set_all(16'h0000, 16'h0000, 16'h0000);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("post_reset_zero", '0);
    end

    $display("[TB] all-ones stimulus");
    set_all(16'h3C00, 16'h3C00, 16'h3C00);
    repeat (4) step();
    check_output("all_ones", exp_ones);
    check_output("all_ones_model", model_csp());

    set_all(16'h3C00, 16'h3C00, 16'hBC00);
    repeat (4) step();
    check_output("neg_cbso", exp_neg);

    $display("[TB] latency from reset release");
    @(negedge clk) reset = 1'b0;
    set_all(16'h0000, 16'h3C00, 16'h3C00);
    @(negedge clk) reset = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    check_output("latency_edge10", '0);
    x = {48{16'h3C00}};
    for (int e = 11; e <= 13; e++) begin
      step();
      check_output($sformatf("latency_edge%0d", e), '0);
    end
    step();
    check_output("latency_edge14", exp_ones);

    $display("[TB] mid-stream reset pulse");
    step();
    check_output("stream_before_pulse", exp_ones);
    reset = 1'b0;
    #1 check_output("mid_reset_immediate", '0);
    #3 reset = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      check_output($sformatf("after_release_edge%0d", e), '0);
    end
    step();
    check_output("after_release_edge4", exp_ones);

    $display("[TB] randomized streaming");
    for (int t = 0; t < 3; t++) begin
      randomize_filters();
      for (int j = 0; j < 8; j++) begin
        randomize_x();
        exp_q[j] = model_csp();
        step();
        if (j >= 3) check_output($sformatf("random_t%0d_j%0d", t, j), exp_q[j-3]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
